alu_result_fifo: RTL and testbench
==================================

Name: alu_result_fifo

Overview:
Downstream capture stage for the 32-bit combinational ALU (inputs a/b/sel, outputs f/ovf_flag).
- Registers each valid ALU result together with its opcode and overflow flag into a small synchronous FIFO.
- Hands results to the writeback/display consumer over a valid/ready interface.
- Keeps sticky overflow status plus saturating overflow and drop counters.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
CNT_W, 16, width of ovf_cnt.
DROP_W, 8, width of drop_cnt.

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  ALU result f/in_ovf/in_sel valid this cycle
in_sel  in  3  opcode applied to the ALU
in_f  in  32  ALU result f
in_ovf  in  1  ALU ovf_flag
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_sel  out  3  head opcode
out_f  out  32  head result
out_ovf  out  1  head overflow (qualified)
full  out  1  count == DEPTH
count  out  $clog2(DEPTH)+1  occupancy
ovf_sticky  out  1  any accepted add/sub overflow since last clear
clr_sticky  in  1  clears ovf_sticky
ovf_cnt  out  CNT_W  accepted overflows, saturating
drop_cnt  out  DROP_W  results lost while full, saturating

Behaviour:
- Reset is synchronous: rst high at a clock edge sets count=0, rd/wr pointers=0, out_valid=0, ovf_sticky=0, ovf_cnt=0, drop_cnt=0. out_f, out_sel and out_ovf read as 0 while empty.
- Reset mid-operation discards all stored entries. rst wins over every other input in the same cycle.
- The ALU stage cannot stall, so there is no in_ready.
- push = in_valid && !full.
- pop = out_valid && out_ready.
- out_valid = (count != 0). The head is presented from storage with no bypass, so latency is one cycle: a result pushed at edge N gives out_valid=1 after edge N.
- Overflow qualification: stored ovf = in_ovf && (in_sel==3'b101 || in_sel==3'b110). in_ovf is ignored for all other opcodes.
- Simultaneous push and pop with count in 1..DEPTH-1: both occur and count is unchanged.
- Push while empty: no pop possible that cycle.
- in_valid while full: entry dropped even if a pop occurs in the same cycle (full is registered state). drop_cnt increments and saturates at all-ones.
- Pointers wrap modulo DEPTH. count is updated as +1 / -1 / 0.
- ovf_sticky: set on a push with qualified ovf; cleared by clr_sticky. A simultaneous set and clear leaves it 1 (set wins).
- ovf_cnt: +1 per push with qualified ovf, saturating at 2^CNT_W-1. Not cleared by clr_sticky.
- Outputs are stable while out_valid && !out_ready.

Optional Feature:
ALU_RESULT_SAT_EN
- Defined: on a push with qualified ovf, the stored f is saturated:
  - in_f[31]==1 (positive true result wrapped) stores 32'h7FFFFFFF;
  - in_f[31]==0 stores 32'h80000000.
  - out_ovf still reports 1.
- Undefined: in_f is stored unmodified (wrapped two's complement).

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_NOT=3'b000, OP_AND=3'b001, OP_XOR=3'b010, OP_OR=3'b011, OP_DEC=3'b100, OP_ADD=3'b101, OP_SUB=3'b110, OP_INC=3'b111;
  - SAT_POS=32'h7FFFFFFF and SAT_NEG=32'h80000000;
  - ENTRY_W=36, packed {sel, ovf, f}.
- One sub-module, alu_res_ram: DEPTH x ENTRY_W register array with synchronous write and asynchronous read. The top handles pointers, counters and flags.

Test Plan:
- Push sel=101, f=32'hFFFFFEF0, ovf=1 (7FFFFFF0+7FFFFF00) -> next cycle out_valid=1, out_ovf=1, ovf_sticky=1, ovf_cnt=1. out_f=32'hFFFFFEF0, or 32'h7FFFFFFF with ALU_RESULT_SAT_EN.
- Push sel=100, f=32'h7FFFFFEF, in_ovf=1 -> out_ovf=0, ovf_cnt unchanged, f never saturated.
- out_ready=0, push 9 results 1..9 -> full=1, count=8, drop_cnt=1. Draining yields 1..8 in order, then out_valid=0.
- count=3, push and pop in the same cycle -> count stays 3. The popped entry is the oldest; the new entry appears after the remaining two.
- Assert clr_sticky in the same cycle as an overflowing add push -> ovf_sticky=1. clr_sticky alone next cycle -> 0, ovf_cnt retained.
- rst high for one cycle with count=5 -> count=0, out_valid=0, all counters 0 after that edge. A push the following cycle is accepted normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, saturation and FIFO-entry definitions for the ALU result capture path.
package alu_pkg;
  localparam logic [2:0] OP_NOT = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_DEC = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_INC = 3'b111;

  localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_NEG = 32'h8000_0000;

  localparam int ENTRY_W = 36;

  typedef struct packed {
    logic [2:0]  sel;
    logic        ovf;
    logic [31:0] f;
  } entry_t;

  // Only add and subtract can overflow in a meaningful way.
  function automatic logic qualify_ovf(input logic [2:0] sel, input logic ovf);
    return ovf && (sel == OP_ADD || sel == OP_SUB);
  endfunction
endpackage

// File: rtl/alu_res_ram.sv
// Register-array storage for the result FIFO: synchronous write, asynchronous read.
module alu_res_ram
  import alu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row
    always_ff @(posedge clk) begin
      if (we && waddr == AW'(gi)) begin
        mem_q[gi] <= wdata;
      end
    end
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/alu_result_fifo.sv
// ALU result capture FIFO with sticky/counted overflow and drop statistics.
// Define ALU_RESULT_SAT_EN to store saturated results for overflowing add/sub.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16,
  parameter int DROP_W = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [2:0]        in_sel,
  input  logic [31:0]       in_f,
  input  logic              in_ovf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_sel,
  output logic [31:0]       out_f,
  output logic              out_ovf,
  output logic              full,
  output logic [CW-1:0]     count,
  output logic              ovf_sticky,
  input  logic              clr_sticky,
  output logic [CNT_W-1:0]  ovf_cnt,
  output logic [DROP_W-1:0] drop_cnt
);
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              sticky_q, sticky_d;
  logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic   push, pop, ovf_qual;
  entry_t wr_entry, rd_entry;

  assign full      = (count_q == CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && !full;
  assign pop       = out_valid && out_ready;
  assign ovf_qual  = qualify_ovf(in_sel, in_ovf);

  always_comb begin
    wr_entry.sel = in_sel;
    wr_entry.ovf = ovf_qual;
`ifdef ALU_RESULT_SAT_EN
    // A set sign bit after signed overflow means the true result was positive.
    wr_entry.f = ovf_qual ? (in_f[31] ? SAT_POS : SAT_NEG) : in_f;
`else
    wr_entry.f = in_f;
`endif
  end

  alu_res_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
    // Set beats clear when both happen together.
    sticky_d   = (push && ovf_qual) ? 1'b1 : (clr_sticky ? 1'b0 : sticky_q);
    ovf_cnt_d  = ovf_cnt_q;
    if (push && ovf_qual && ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
    drop_cnt_d = drop_cnt_q;
    if (in_valid && full && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sticky_q   <= 1'b0;
      ovf_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sticky_q   <= sticky_d;
      ovf_cnt_q  <= ovf_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign count      = count_q;
  assign ovf_sticky = sticky_q;
  assign ovf_cnt    = ovf_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign out_sel    = out_valid ? rd_entry.sel : 3'b000;
  assign out_ovf    = out_valid ? rd_entry.ovf : 1'b0;
  assign out_f      = out_valid ? rd_entry.f : 32'h0;
endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed and random checks of alu_result_fifo against a queue-based reference model.
module tb_alu_result_fifo;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;
  localparam int DROP_W = 4;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  typedef struct packed {
    logic [2:0]  sel;
    logic        ovf;
    logic [31:0] f;
  } ent_t;

  logic clk = 1'b0;
  logic rst, in_valid, in_ovf, out_ready, clr_sticky;
  logic [2:0]  in_sel;
  logic [31:0] in_f;
  logic out_valid, out_ovf, full, ovf_sticky;
  logic [2:0]  out_sel;
  logic [31:0] out_f;
  logic [CW-1:0]     count;
  logic [CNT_W-1:0]  ovf_cnt;
  logic [DROP_W-1:0] drop_cnt;

  ent_t mq[$];
  bit   m_sticky;
  int   m_ovf, m_drop;
  int   total = 0, bad = 0;

  always #5 clk = ~clk;

  alu_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sel(in_sel), .in_f(in_f),
    .in_ovf(in_ovf), .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel), .out_f(out_f), .out_ovf(out_ovf), .full(full),
    .count(count), .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky),
    .ovf_cnt(ovf_cnt), .drop_cnt(drop_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    ent_t h;
    h = (mq.size() != 0) ? mq[0] : '0;
    check("count", 64'(count), 64'(mq.size()));
    check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    check("full", 64'(full), 64'(mq.size() == DEPTH));
    check("out_sel", 64'(out_sel), 64'(h.sel));
    check("out_ovf", 64'(out_ovf), 64'(h.ovf));
    check("out_f", 64'(out_f), 64'(h.f));
    check("ovf_sticky", 64'(ovf_sticky), 64'(m_sticky));
    check("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic step(input bit r, input bit v, input logic [2:0] s, input logic [31:0] f,
                      input bit o, input bit rdy, input bit clr);
    bit full_m, pop_m, push_m, q;
    logic [31:0] fs;
    rst = r; in_valid = v; in_sel = s; in_f = f; in_ovf = o; out_ready = rdy; clr_sticky = clr;
    @(posedge clk);
    #1;
    if (r) begin
      mq.delete(); m_sticky = 0; m_ovf = 0; m_drop = 0;
    end else begin
      full_m = (mq.size() == DEPTH);
      pop_m  = (mq.size() != 0) && rdy;
      push_m = v && !full_m;
      q      = o && (s == 3'd5 || s == 3'd6);
`ifdef ALU_RESULT_SAT_EN
      fs = q ? (f[31] ? 32'h7FFFFFFF : 32'h80000000) : f;
`else
      fs = f;
`endif
      if (pop_m) void'(mq.pop_front());
      if (push_m) mq.push_back({s, q, fs});
      if (clr) m_sticky = 0;
      if (push_m && q) begin
        m_sticky = 1;
        if (m_ovf < CNT_MAX) m_ovf++;
      end
      if (v && full_m && m_drop < DROP_MAX) m_drop++;
    end
    $display("t=%0t rst=%0d v=%0d sel=%0d f=%h ovf=%0d rdy=%0d clr=%0d -> cnt=%0d head=%h",
             $time, r, v, s, f, o, rdy, clr, count, out_f);
    check_all();
  endtask

  initial begin
    step(1, 1, 3'd5, 32'h1234, 1, 0, 0);
    check("rst_count", 64'(count), 64'd0);

    // Overflowing add.
    step(0, 1, 3'd5, 32'hFFFFFEF0, 1, 0, 0);
    check("add_ovf", 64'(out_ovf), 64'd1);
    check("add_cnt", 64'(ovf_cnt), 64'd1);
`ifdef ALU_RESULT_SAT_EN
    check("add_f", 64'(out_f), 64'h7FFFFFFF);
`else
    check("add_f", 64'(out_f), 64'hFFFFFEF0);
`endif
    step(0, 0, 3'd0, 32'h0, 0, 1, 0);

    // DEC with in_ovf set is not qualified.
    step(0, 1, 3'd4, 32'h7FFFFFEF, 1, 0, 0);
    check("dec_ovf", 64'(out_ovf), 64'd0);
    check("dec_f", 64'(out_f), 64'h7FFFFFEF);
    step(0, 0, 3'd0, 32'h0, 0, 1, 0);

    // Fill with 1..9, the ninth is dropped, then drain.
    for (int i = 1; i <= 9; i++) step(0, 1, 3'd1, 32'(i), 1, 0, 0);
    check("fill_cnt", 64'(count), 64'd8);
    check("fill_drop", 64'(drop_cnt), 64'd1);
    // Push while full with a pop in the same cycle is still dropped.
    step(0, 1, 3'd2, 32'hAA, 0, 1, 0);
    check("full_pop_drop", 64'(drop_cnt), 64'd2);
    for (int i = 0; i < 8; i++) step(0, 0, 3'd0, 32'h0, 0, 1, 0);
    check("drained", 64'(out_valid), 64'd0);

    // Simultaneous push/pop at count 3.
    for (int i = 0; i < 3; i++) step(0, 1, 3'd3, 32'h100 + 32'(i), 0, 0, 0);
    step(0, 1, 3'd3, 32'h200, 0, 1, 0);
    check("pp_count", 64'(count), 64'd3);
    check("pp_head", 64'(out_f), 64'h101);
    for (int i = 0; i < 3; i++) step(0, 0, 3'd0, 32'h0, 0, 1, 0);

    // Clear versus set in the same cycle.
    step(0, 0, 3'd0, 32'h0, 0, 1, 1);
    step(0, 1, 3'd6, 32'h00000010, 1, 1, 1);
    check("set_wins", 64'(ovf_sticky), 64'd1);
    step(0, 0, 3'd0, 32'h0, 0, 1, 1);
    check("clr_only", 64'(ovf_sticky), 64'd0);
    check("cnt_kept", 64'(ovf_cnt), 64'd2);

    // Reset with 5 entries, then a push.
    for (int i = 0; i < 5; i++) step(0, 1, 3'd5, 32'hF0000000 + 32'(i), 1, 0, 0);
    step(1, 1, 3'd5, 32'h1, 1, 1, 0);
    check("rst_mid", 64'(count), 64'd0);
    step(0, 1, 3'd7, 32'h55, 0, 0, 0);
    check("post_rst", 64'(count), 64'd1);

    // Saturation of both counters.
    for (int i = 0; i < 30; i++) step(0, 1, 3'd5, 32'(i) << 28, 1, 0, 0);
    check("drop_sat", 64'(drop_cnt), 64'(DROP_MAX));
    for (int i = 0; i < 8; i++) step(0, 0, 3'd0, 32'h0, 0, 1, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 3'd6, 32'h80000000, 1, 1, 0);
    check("ovf_sat", 64'(ovf_cnt), 64'(CNT_MAX));

    // Random traffic.
    step(1, 0, 3'd0, 32'h0, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      step(0, bit'($urandom_range(0, 2) != 0), 3'($urandom), $urandom,
           bit'($urandom), bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 7) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
